board_ram_arbiter: RTL
======================

Name: board_ram_arbiter

Overview:
Shares the single-port board RAM (256 x 6-bit, `ram_board`) between the game-logic engines that all need it: collision detect, piece lock/write-back and line clear. Each requester gets exclusive burst ownership of the RAM port, granted round-robin with an optional burst cap. Read data is routed back to whichever requester issued the read, with correct RAM latency, even after ownership has moved. The block sits between the `control` FSM's engines and `ram_board`, replacing direct wiring of `ram_addr`.

Parameters:
N_REQ, 3, number of requesters (index 0 = collision, 1 = lock, 2 = line clear)
ADDR_W, 8, board RAM address width
DATA_W, 6, board cell/colour width
RD_LAT, 1, RAM read latency in cycles from address-presented cycle to valid q (1..3)
MAX_BURST, 0, max accesses per grant before forced release if others wait; 0 = unlimited

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester request; held high for whole burst
wren  in  N_REQ  per-requester write strobe for current access
addr  in  N_REQ*ADDR_W  packed per-requester address, requester i at [i*ADDR_W +: ADDR_W]
wdata  in  N_REQ*DATA_W  packed per-requester write data
gnt  out  N_REQ  registered one-hot (or zero) grant
rvalid  out  N_REQ  one-hot read-return strobe
rdata  out  DATA_W  read data, shared, qualified by rvalid
ram_addr  out  ADDR_W  to `ram_board` address
ram_data  out  DATA_W  to `ram_board` data
ram_wren  out  1  to `ram_board` wren
ram_q  in  DATA_W  from `ram_board` q
busy  out  1  high whenever gnt != 0

Behaviour:
- Reset values (async): gnt=0, rvalid=0, busy=0, rdata=0, round-robin pointer=0, burst counter=0, return pipeline cleared.
- FSM states:
  - IDLE: gnt=0. If any req is high, register a grant to the first requesting index at or after the pointer, wrapping modulo N_REQ. Move to OWN.
  - OWN(i): while req[i]=1, stay in OWN.
  - OWN -> IDLE-arbitrate happens in the same cycle req[i] falls. The next grant is registered for the following cycle, so there is one dead cycle minimum between owners. The pointer is set to (i+1) mod N_REQ.
- Access cycle: any cycle with gnt[i]=1 and req[i]=1.
  - RAM outputs are driven combinationally from requester i: ram_addr=addr[i], ram_data=wdata[i], ram_wren=wren[i].
  - In any non-access cycle: ram_wren=0, ram_addr=0, ram_data=0.
- Request latency: req rising in cycle n with RAM idle gives gnt in cycle n+1; the first access is cycle n+1.
- Read return: each access cycle with wren=0 pushes {valid, i} into an RD_LAT-deep shift register.
  - rvalid[i]=1 and rdata=ram_q exactly RD_LAT cycles later, for one cycle.
  - This holds even if gnt[i] has since dropped.
  - Writes produce no rvalid.
- Burst cap (MAX_BURST>0):
  - The counter counts access cycles in the current grant.
  - When the count reaches MAX_BURST and any other req is high, gnt[i] drops next cycle and the pointer advances.
  - The requester keeps req high and is re-granted by round-robin later.
  - If no one else requests, the counter saturates and ownership continues.
- Simultaneous events:
  - Two or more requests rising together are resolved by the pointer only.
  - A req dropping while another rises in the same cycle gives the new grant next cycle.
- req low while not granted: ignored, no state change.
- gnt is never multi-hot. gnt[i] is never asserted unless req[i] was high the previous cycle.
- Reset mid-burst: grant is lost and in-flight read returns are discarded (no rvalid). RAM contents are untouched.

Decomposition:
- Shared package `tetris_pkg`:
  - BOARD_ADDR_W=8, CELL_W=6, N_BOARD_REQ=3.
  - Requester indices REQ_COLLISION=0, REQ_LOCK=1, REQ_LINECLR=2.
  - Arbiter FSM state encodings.
- One sub-module: `rr_pick`, a combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner and a valid flag.
  - Reusable for the VGA draw-port arbiter.

Test Plan:
- Single requester: req[0]=1 at cycle 5, addr=8'h21, wren=0 for 3 cycles, RD_LAT=1 -> gnt[0]=1 from cycle 6; rvalid[0] in cycles 7..9 with rdata equal to RAM contents of 8'h21; ram_wren=0 throughout.
- Contention: req[0], req[1], req[2] all rise at cycle 3 after reset -> grant order 0, 1, 2. Each grant follows the previous req fall by exactly one cycle; never multi-hot.
- Write then read-back: requester 1 writes 6'h2A to 8'h05, releases; requester 0 reads 8'h05 -> rvalid[0] with rdata=6'h2A.
- Read return after release: requester 2 reads 8'h10 on its last granted cycle and drops req; requester 0 is granted next -> rvalid[2] still fires RD_LAT cycles after the read, and rvalid[0] is not asserted for it.
- Burst cap: MAX_BURST=4, req[0] held, req[1] rises at cycle 2 of the burst -> gnt[0] drops after its 4th access; gnt[1] the cycle after; gnt[0] returns once req[1] falls.
- Async reset mid-burst: assert reset between clock edges with a read in flight -> gnt, rvalid and busy go to 0 immediately; no stale rvalid after deassertion; the first post-reset grant goes to requester 0 if all request.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared game-logic constants: board RAM geometry, requester indices and arbiter state encodings.
// Imported by every block that touches ram_board.
package tetris_pkg;

    localparam int BOARD_ADDR_W = 8;
    localparam int CELL_W       = 6;
    localparam int N_BOARD_REQ  = 3;

    localparam int REQ_COLLISION = 0;
    localparam int REQ_LOCK      = 1;
    localparam int REQ_LINECLR   = 2;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    // Next round-robin slot after idx, wrapping modulo n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/board_ram_arbiter_if.sv
// Requester-side bundle of the board RAM arbiter: per-engine request/access lines and grant/read return.
// master = the game-logic engines, slave = the arbiter.
interface board_ram_arbiter_if
    import tetris_pkg::*;
#(
    parameter int N_REQ  = N_BOARD_REQ,
    parameter int ADDR_W = BOARD_ADDR_W,
    parameter int DATA_W = CELL_W
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        wren;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;

    modport master (
        output req, wren, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wren, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
// Zero latency; vld low when nothing requests.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic             vld
);

    int idx;

    always_comb begin
        win = '0;
        vld = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!vld && req[idx]) begin
                win[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// Shares the single-port board RAM between game engines with round-robin burst ownership and an optional burst cap.
// Grant one cycle after request; reads return RD_LAT cycles after the access, routed to the issuing requester.
module board_ram_arbiter
    import tetris_pkg::*;
#(
    parameter int N_REQ     = N_BOARD_REQ,
    parameter int ADDR_W    = BOARD_ADDR_W,
    parameter int DATA_W    = CELL_W,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 0
) (
    input  logic              clk,
    input  logic              reset,
    board_ram_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_e                     state_q, state_d;
    logic [N_REQ-1:0]               gnt_q, gnt_d;
    logic [IDX_W-1:0]               owner_q, owner_d;
    logic [IDX_W-1:0]               ptr_q, ptr_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [RD_LAT-1:0]              pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0][IDX_W-1:0]   pipe_idx_q, pipe_idx_d;

    logic              owner_req;
    logic              owner_wren;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              access;
    logic              others_req;
    logic [IDX_W-1:0]  ptr_next;
    logic [IDX_W-1:0]  pick_ptr;
    logic [N_REQ-1:0]  pick_win;
    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic [CNT_W-1:0]  cnt_inc;
    logic [N_REQ-1:0]  rvalid_c;

    always_comb begin
        owner_req  = 1'b0;
        owner_wren = 1'b0;
        sel_addr   = '0;
        sel_data   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_req  = bus.req[i];
                owner_wren = bus.wren[i];
                sel_addr   = bus.addr[i*ADDR_W +: ADDR_W];
                sel_data   = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign access     = (state_q == ARB_OWN) && owner_req;
    assign others_req = |(bus.req & ~gnt_q);
    assign ptr_next   = IDX_W'(wrap_inc(int'(owner_q), N_REQ));

    // When the owner lets go we arbitrate in the same cycle, starting after the owner.
    assign pick_ptr = (state_q == ARB_OWN) ? ptr_next : ptr_q;

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (IDX_W)
    ) u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .win (pick_win),
        .vld (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_win[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    assign ram_addr = access ? sel_addr   : '0;
    assign ram_data = access ? sel_data   : '0;
    assign ram_wren = access ? owner_wren : 1'b0;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d = ARB_OWN;
                    gnt_d   = pick_win;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_OWN: begin
                if (!owner_req) begin
                    ptr_d = ptr_next;
                    cnt_d = '0;
                    if (pick_vld) begin
                        gnt_d   = pick_win;
                        owner_d = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end else if (MAX_BURST > 0) begin
                    cnt_d = cnt_inc;
                    // Cap reached with someone waiting: release through IDLE so the waiter wins next.
                    if ((cnt_inc == CNT_MAX) && others_req) begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                        ptr_d   = ptr_next;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pipe_vld_d    = '0;
        pipe_idx_d    = '0;
        pipe_vld_d[0] = access && !owner_wren;
        pipe_idx_d[0] = owner_q;
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_idx_d[k] = pipe_idx_q[k-1];
        end
    end

    always_comb begin
        rvalid_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rvalid_c[i] = pipe_vld_q[RD_LAT-1] && (pipe_idx_q[RD_LAT-1] == IDX_W'(i));
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_c;
    assign bus.rdata  = pipe_vld_q[RD_LAT-1] ? ram_q : '0;
    assign busy       = |gnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            pipe_vld_q <= '0;
            pipe_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_idx_q <= pipe_idx_d;
        end
    end

endmodule
